// File: rtl/seg_history_scan.sv
// Four-deep code history shown on a scanned 4-digit active-low seven-segment display.
// Optional macro SEG_BLINK_EN: blink digit 0 with a BLINK_DIV half-period.
module seg_history_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       in_valid,
  input  logic [3:0] in_code,
  output logic [6:0] seven_seg,
  output logic [3:0] seven_enable,
  output logic [2:0] depth
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [3:0][3:0] hist_q, hist_d;
  logic [3:0]      fill_q, fill_d;
  logic [2:0]      depth_q, depth_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [6:0]      seg_q, seg_d;
  logic [3:0]      en_q, en_d;
  logic            blank_blink;

  function automatic logic [6:0] hex7(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // History shift register; clear beats a same-cycle push.
  always_comb begin
    hist_d  = hist_q;
    fill_d  = fill_q;
    depth_d = depth_q;
    if (clr) begin
      hist_d  = '0;
      fill_d  = '0;
      depth_d = '0;
    end else if (in_valid) begin
      hist_d  = {hist_q[2:0], in_code};
      fill_d  = {fill_q[2:0], 1'b1};
      depth_d = (depth_q == 3'd4) ? 3'd4 : depth_q + 3'd1;
    end
  end

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

`ifdef SEG_BLINK_EN
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               phase_q, phase_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q + BLINK_W'(1);
    phase_d     = phase_q;
    if (clr) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign blank_blink = phase_q && (idx_q == 2'd0);
`else
  assign blank_blink = 1'b0;
`endif

  // Output stage reflects the index and history held in the registers this cycle.
  always_comb begin
    seg_d = 7'b1111111;
    en_d  = 4'b1111;
    if (fill_q[idx_q] && !blank_blink) begin
      seg_d = hex7(hist_q[idx_q]);
      en_d  = ~(4'b0001 << idx_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q  <= '0;
      fill_q  <= '0;
      depth_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      seg_q   <= 7'b1111111;
      en_q    <= 4'b1111;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      depth_q <= depth_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      en_q    <= en_d;
    end
  end

  assign seven_seg    = seg_q;
  assign seven_enable = en_q;
  assign depth        = depth_q;

endmodule
